// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle between the control unit (master)
// and the shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [CNT_W-1:0] req_count;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_count, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_count, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle controller that iterates a single-step shifter (sll8 / sra1)
// through an accumulator and returns the final word over a handshake.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]  sh_in_o,
  output logic              sh_sll8_o,
  output logic              sh_sra1_o,
  input  logic [WIDTH-1:0]  sh_out_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Four byte shifts already clear a 32-bit word, so longer left shifts are capped.
  localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(4);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             op_q, op_d;
  logic [CNT_W-1:0] eff_count;

  always_comb begin
    eff_count = bus.req_count;
    if (!bus.req_op && (bus.req_count > MAX_BYTES)) begin
      eff_count = MAX_BYTES;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      op_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      op_q        <= op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    op_d        = op_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          acc_d       = bus.req_data;
          op_d        = bus.req_op;
          remaining_d = eff_count;
          state_d     = (eff_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d       = sh_out_i;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode registered state only; nothing combinational from req_*.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = acc_q;
  assign sh_in_o       = acc_q;
  assign sh_sll8_o     = (state_q == RUN) & ~op_q;
  assign sh_sra1_o     = (state_q == RUN) &  op_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized and directed bench for shift_sequencer, with a behavioural
// shifter and a reference result model.
module tb_shift_sequencer;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sh_in;
  logic             sh_sll8;
  logic             sh_sra1;
  logic [WIDTH-1:0] sh_out;

  int checks = 0;
  int errors = 0;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sh_in_o   (sh_in),
    .sh_sll8_o (sh_sll8),
    .sh_sra1_o (sh_sra1),
    .sh_out_i  (sh_out)
  );

  always #5 clk = ~clk;

  // Single-step shifter the sequencer drives.
  always_comb begin
    sh_out = sh_in;
    if (sh_sll8)      sh_out = sh_in << 8;
    else if (sh_sra1) sh_out = WIDTH'($signed(sh_in) >>> 1);
  end

  function automatic int eff_passes(input logic op, input logic [CNT_W-1:0] cnt);
    int c;
    c = int'(cnt);
    if (!op && c > 4) c = 4;
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] model(input logic op, input logic [CNT_W-1:0] cnt,
                                             input logic [WIDTH-1:0] data);
    int c;
    c = int'(cnt);
    if (!op) return (c >= 4) ? '0 : (data << (8 * c));
    return WIDTH'($signed(data) >>> c);
  endfunction

  task automatic do_req(input logic op, input logic [CNT_W-1:0] cnt,
                        input logic [WIDTH-1:0] data, input int hold, input string name);
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] held;
    int eff, lat, n_sll, n_sra, n_both, n_rdy;
    bit got;
    exp = model(op, cnt, data);
    eff = eff_passes(op, cnt);
    n_sll = 0; n_sra = 0; n_both = 0; n_rdy = 0; lat = 1; got = 0;

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_count = cnt;
    bus.req_data  = data;
    bus.rsp_ready = (hold == 0);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept req_ready got %b want 1", name, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_data  = $urandom;
    bus.req_count = CNT_W'($urandom);
    bus.req_op    = 1'($urandom);

    for (int k = 0; k < 64; k++) begin
      if (sh_sll8) n_sll++;
      if (sh_sra1) n_sra++;
      if (sh_sll8 && sh_sra1) n_both++;
      if (bus.req_ready) n_rdy++;
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
      lat++;
      @(negedge clk);
    end

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout rsp_valid never rose", name);
      return;
    end
    checks++;
    if (lat !== eff + 1) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, eff + 1);
    end
    checks++;
    if (bus.rsp_data !== exp) begin
      errors++;
      $display("FAIL %s rsp_data got %h want %h", name, bus.rsp_data, exp);
    end
    checks++;
    if (n_sll !== (op ? 0 : eff) || n_sra !== (op ? eff : 0) || n_both !== 0) begin
      errors++;
      $display("FAIL %s pulses sll8/sra1/both got %0d/%0d/%0d want %0d/%0d/0", name,
               n_sll, n_sra, n_both, op ? 0 : eff, op ? eff : 0);
    end
    checks++;
    if (n_rdy !== 0) begin
      errors++;
      $display("FAIL %s busy req_ready high %0d cycles want 0", name, n_rdy);
    end

    held = bus.rsp_data;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = $urandom;
      bus.req_op    = 1'($urandom);
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d valid/data/ready got %b/%h/%b want 1/%h/0", name, h,
                 bus.rsp_valid, bus.rsp_data, bus.req_ready, held);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || sh_sll8 || sh_sra1) begin
      errors++;
      $display("FAIL %s return ready/valid got %b/%b want 1/0", name, bus.req_ready, bus.rsp_valid);
    end
    $display("txn %s op=%0d cnt=%0d data=%h rsp=%h exp=%h lat=%0d hold=%0d",
             name, op, cnt, data, held, exp, lat, hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_count = '0;
    bus.req_data = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
        sh_in !== '0 || sh_sll8 !== 1'b0 || sh_sra1 !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs ready/valid/data/sll/sra got %b/%b/%h/%b/%b want 1/0/0/0/0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, sh_sll8, sh_sra1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || sh_sll8 || sh_sra1) begin
      errors++;
      $display("FAIL idle ready/valid got %b/%b want 1/0", bus.req_ready, bus.rsp_valid);
    end
    $display("txn reset done");
  endtask

  task automatic test_directed();
    do_req(1'b0, 5'd2,  32'h0000_12AB, 0, "sll_2");
    do_req(1'b1, 5'd4,  32'h8000_0010, 0, "sra_4");
    do_req(1'b1, 5'd0,  32'h7FFF_FFFF, 0, "sra_0");
    do_req(1'b0, 5'd9,  32'hFFFF_FFFF, 0, "sll_cap");
    do_req(1'b0, 5'd0,  32'hDEAD_BEEF, 0, "sll_0");
    do_req(1'b1, 5'd31, 32'h9234_5678, 0, "sra_31n");
    do_req(1'b1, 5'd31, 32'h1234_5678, 0, "sra_31p");
    do_req(1'b0, 5'd4,  32'h0000_00FF, 0, "sll_4");
  endtask

  task automatic test_backpressure();
    do_req(1'b1, 5'd3, 32'hC001_0F0F, 5, "bp_sra");
    do_req(1'b0, 5'd1, 32'h00AB_CDEF, 5, "bp_sll");
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_count = 5'd20;
    bus.req_data = 32'hF0F0_1234; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sh_sra1 !== 1'b1) begin
      errors++;
      $display("FAIL abort_run sh_sra1 got %b want 1", sh_sra1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
        sh_in !== '0 || sh_sll8 !== 1'b0 || sh_sra1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset ready/valid/data/sra got %b/%b/%h/%b want 1/0/0/0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, sh_sra1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.req_ready) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_after spurious activity got 1 want 0");
    end
    $display("txn abort done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom), CNT_W'($urandom), $urandom, int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
